// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg : shared hex-to-7-segment table and output idle levels       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg_pkg;

    typedef logic [6:0] seg7_t;

    // Segment order {g,f,e,d,c,b,a}; entry n is the pattern for nibble n
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic OFF_ACT_HIGH = 1'b0;
    localparam logic OFF_ACT_LOW  = 1'b1;

    function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_hex_decode : combinational nibble to 7-segment pattern           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      segs
);

    assign segs = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/seg_mux_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_mux_scan : multiplexed 7-seg scanner with PWM, guard phase,      |
// | leading-zero blanking and double-buffered data                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_mux_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 4096,
    parameter int BRIGHT_BITS    = 3,
    parameter bit DRAIN_ACT_HIGH = 1'b1,
    parameter bit SEG_ACT_HIGH   = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    oe,
    input  logic                    blank_lz,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [NUM_DIGITS-1:0]   drains,
    output logic [7:0]              leds,
    output logic                    frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SUB   = PRESCALE >> BRIGHT_BITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] DRAINS_OFF =
        {NUM_DIGITS{DRAIN_ACT_HIGH ? OFF_ACT_HIGH : OFF_ACT_LOW}};
    localparam logic [7:0] LEDS_OFF = {8{SEG_ACT_HIGH ? OFF_ACT_HIGH : OFF_ACT_LOW}};

    logic [CNT_W-1:0]        cnt;
    logic [DIG_W-1:0]        digit;
    logic [4*NUM_DIGITS-1:0] shadow_data, act_data;
    logic [NUM_DIGITS-1:0]   shadow_dp, act_dp;

    logic                    boundary;
    logic [BRIGHT_BITS-1:0]  phase;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   onehot;
    seg7_t                   segs;

    assign boundary = oe && (cnt == CNT_LAST) && (digit == DIG_LAST);
    assign phase    = BRIGHT_BITS'(32'(cnt) / SUB);

    // A digit is blankable only if every digit from it upward is a bare zero
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
            blank[i] = blank_lz && zero_run;
        end
    end

    // Phase 0 of every slot stays dark so the previous digit's charge drains off
    assign lit    = oe && (phase != '0) && (phase <= brightness) && !blank[digit];
    assign onehot = NUM_DIGITS'(1) << digit;

    seg_hex_decode u_decode (
        .nibble (act_data[4*digit +: 4]),
        .segs   (segs)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt         <= '0;
            digit       <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            act_data    <= '0;
            act_dp      <= '0;
            drains      <= DRAINS_OFF;
            leds        <= LEDS_OFF;
            frame_done  <= 1'b0;
        end else begin
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp;
            end

            if (!oe || boundary) begin
                act_data <= load ? data : shadow_data;
                act_dp   <= load ? dp   : shadow_dp;
            end

            if (!oe) begin
                cnt   <= '0;
                digit <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            drains     <= (lit ? onehot : '0) ^ DRAINS_OFF;
            leds       <= (lit ? {act_dp[digit], segs} : 8'h00) ^ LEDS_OFF;
            frame_done <= boundary;
        end
    end

endmodule
`default_nettype wire
